// File: rtl/lut_mult_accum_if.sv
// Product stream in, frame-result stream out, for the LUT multiplier accumulator.
interface lut_mult_accum_if #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
);
  logic             prod_valid;
  logic             prod_ready;
  logic [15:0]      prod_data;
  logic             prod_last;
  logic             sum_valid;
  logic             sum_ready;
  logic [ACC_W-1:0] sum_data;
  logic [CNT_W-1:0] sum_count;
  logic             sum_ovf;

  modport master (
    output prod_valid, prod_data, prod_last, sum_ready,
    input  prod_ready, sum_valid, sum_data, sum_count, sum_ovf
  );

  modport slave (
    input  prod_valid, prod_data, prod_last, sum_ready,
    output prod_ready, sum_valid, sum_data, sum_count, sum_ovf
  );
endinterface

// File: rtl/lut_mult_accum.sv
// Saturating frame accumulator for 16-bit products; one result register on the output.
// state    | meaning
// ACC_IDLE | acc, cnt, ovf cleared; no term of the current frame absorbed yet
// ACC_RUN  | at least one non-last term of the current frame absorbed
module lut_mult_accum #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  lut_mult_accum_if.slave    bus
);

  typedef enum logic {ACC_IDLE, ACC_RUN} acc_state_t;

  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             sum_valid_q, sum_valid_d;
  logic [ACC_W-1:0] sum_data_q, sum_data_d;
  logic [CNT_W-1:0] sum_count_q, sum_count_d;
  logic             sum_ovf_q, sum_ovf_d;

  logic             prod_ready;
  logic             beat_acc;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] acc_upd;
  logic [CNT_W-1:0] cnt_upd;
  logic             ovf_upd;

  // Only a last beat can be blocked, since only it writes the result register.
  assign prod_ready = !(sum_valid_q && !bus.sum_ready && bus.prod_last);
  assign beat_acc   = bus.prod_valid && prod_ready;

  always_comb begin
    sum_wide = {1'b0, acc_q} + (ACC_W+1)'(bus.prod_data);
    acc_upd  = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
    ovf_upd  = ovf_q | sum_wide[ACC_W];
    cnt_upd  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    sum_valid_d = sum_valid_q && !bus.sum_ready;
    sum_data_d  = sum_data_q;
    sum_count_d = sum_count_q;
    sum_ovf_d   = sum_ovf_q;

    if (beat_acc) begin
      if (bus.prod_last) begin
        sum_valid_d = 1'b1;
        sum_data_d  = acc_upd;
        sum_count_d = cnt_upd;
        sum_ovf_d   = ovf_upd;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d = acc_upd;
        cnt_d = cnt_upd;
        ovf_d = ovf_upd;
      end
    end

    case (state_q)
      ACC_IDLE: if (beat_acc && !bus.prod_last) state_d = ACC_RUN;
      ACC_RUN:  if (beat_acc && bus.prod_last)  state_d = ACC_IDLE;
      default:  state_d = ACC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      sum_valid_q <= 1'b0;
      sum_data_q  <= '0;
      sum_count_q <= '0;
      sum_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      sum_valid_q <= sum_valid_d;
      sum_data_q  <= sum_data_d;
      sum_count_q <= sum_count_d;
      sum_ovf_q   <= sum_ovf_d;
    end
  end

  assign bus.prod_ready = prod_ready;
  assign bus.sum_valid  = sum_valid_q;
  assign bus.sum_data   = sum_data_q;
  assign bus.sum_count  = sum_count_q;
  assign bus.sum_ovf    = sum_ovf_q;

endmodule

// File: tb/tb_lut_mult_accum.sv
// Bench for lut_mult_accum: vector table, corner sequences, and a random run against a frame-level model.
module tb_lut_mult_accum;

  localparam int ACC_W = 24;
  localparam int CNT_W = 8;
  localparam longint MAXA = (longint'(1) << ACC_W) - 1;
  localparam longint MAXC = (longint'(1) << CNT_W) - 1;

  logic clk;
  logic rst_n;

  lut_mult_accum_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) m_if ();
  lut_mult_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m_if)
  );

  // Narrow instance for overflow and count saturation.
  lut_mult_accum_if #(.ACC_W(16), .CNT_W(2)) s_if ();
  lut_mult_accum #(.ACC_W(16), .CNT_W(2)) u_dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        pv;
    logic [15:0] pd;
    logic        pl;
    logic        sr;
    logic        rdy;
    logic        sv;
    logic [23:0] sd;
    logic [7:0]  sc;
    logic        so;
  } vec_t;

  function automatic vec_t mk(logic pv, logic [15:0] pd, logic pl, logic sr,
                              logic rdy, logic sv, logic [23:0] sd, logic [7:0] sc, logic so);
    vec_t v;
    v.pv = pv; v.pd = pd; v.pl = pl; v.sr = sr;
    v.rdy = rdy; v.sv = sv; v.sd = sd; v.sc = sc; v.so = so;
    return v;
  endfunction

  typedef struct {
    longint data;
    longint cnt;
    bit     ovf;
  } res_t;

  res_t   mq[$];
  res_t   last_out;
  longint msum;
  longint mn;

  function automatic res_t frame_result(longint s, longint n);
    res_t r;
    r.data = (s > MAXA) ? MAXA : s;
    r.ovf  = (s > MAXA);
    r.cnt  = (n > MAXC) ? MAXC : n;
    return r;
  endfunction

  task automatic m_check_outputs(input string tag, input logic sv, input longint d,
                                 input longint c, input bit o);
    check({tag, ".sum_valid"}, m_if.sum_valid, sv);
    check({tag, ".sum_data"},  m_if.sum_data, d);
    check({tag, ".sum_count"}, m_if.sum_count, c);
    check({tag, ".sum_ovf"},   m_if.sum_ovf, o);
  endtask

  task automatic s_beat(input logic [15:0] d, input logic l);
    @(posedge clk); #1;
    s_if.prod_valid = 1'b1;
    s_if.prod_data  = d;
    s_if.prod_last  = l;
    #1;
    check("narrow.prod_ready", s_if.prod_ready, 1'b1);
  endtask

  task automatic s_result(input string tag, input longint d, input longint c, input bit o);
    @(posedge clk); #1;
    s_if.prod_valid = 1'b0;
    s_if.prod_last  = 1'b0;
    #1;
    check({tag, ".sum_valid"}, s_if.sum_valid, 1'b1);
    check({tag, ".sum_data"},  s_if.sum_data, d);
    check({tag, ".sum_count"}, s_if.sum_count, c);
    check({tag, ".sum_ovf"},   s_if.sum_ovf, o);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_phase(input int cycles, input int last_div, input int dmin);
    logic   exp_valid, exp_ready;
    res_t   front;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      m_if.prod_valid = ($urandom_range(0, 3) != 0);
      m_if.prod_data  = 16'($urandom_range(dmin, 65535));
      m_if.prod_last  = ($urandom_range(0, last_div - 1) == 0);
      m_if.sum_ready  = ($urandom_range(0, 3) != 0);
      #1;
      exp_valid = (mq.size() != 0);
      exp_ready = !(exp_valid && !m_if.sum_ready && m_if.prod_last);
      check("rand.prod_ready", m_if.prod_ready, exp_ready);
      front = exp_valid ? mq[0] : last_out;
      m_check_outputs("rand", exp_valid, front.data, front.cnt, front.ovf);
      if (exp_valid && m_if.sum_ready) last_out = mq.pop_front();
      if (m_if.prod_valid && exp_ready) begin
        msum += longint'(m_if.prod_data);
        mn++;
        if (m_if.prod_last) begin
          mq.push_back(frame_result(msum, mn));
          msum = 0;
          mn   = 0;
        end
      end
    end
  endtask

  vec_t vt[20];

  initial begin
    rst_n = 1'b0;
    m_if.prod_valid = 1'b0; m_if.prod_data = '0; m_if.prod_last = 1'b1; m_if.sum_ready = 1'b0;
    s_if.prod_valid = 1'b0; s_if.prod_data = '0; s_if.prod_last = 1'b0; s_if.sum_ready = 1'b1;

    vt[0]  = mk(1, 3,  0, 1, 1, 0, 0,  0, 0);
    vt[1]  = mk(1, 6,  0, 1, 1, 0, 0,  0, 0);
    vt[2]  = mk(1, 9,  1, 1, 1, 0, 0,  0, 0);
    vt[3]  = mk(0, 0,  0, 1, 1, 1, 18, 3, 0);
    vt[4]  = mk(0, 0,  0, 1, 1, 0, 18, 3, 0);
    vt[5]  = mk(1, 3,  0, 0, 1, 0, 18, 3, 0);
    vt[6]  = mk(1, 6,  0, 0, 1, 0, 18, 3, 0);
    vt[7]  = mk(1, 9,  1, 0, 1, 0, 18, 3, 0);
    vt[8]  = mk(1, 4,  0, 0, 1, 1, 18, 3, 0);
    vt[9]  = mk(1, 5,  0, 0, 1, 1, 18, 3, 0);
    vt[10] = mk(1, 7,  1, 0, 0, 1, 18, 3, 0);
    vt[11] = mk(1, 7,  1, 0, 0, 1, 18, 3, 0);
    vt[12] = mk(1, 7,  1, 1, 1, 1, 18, 3, 0);
    vt[13] = mk(0, 0,  0, 1, 1, 1, 16, 3, 0);
    vt[14] = mk(0, 0,  0, 1, 1, 0, 16, 3, 0);
    vt[15] = mk(1, 10, 1, 1, 1, 0, 16, 3, 0);
    vt[16] = mk(1, 20, 1, 1, 1, 1, 10, 1, 0);
    vt[17] = mk(1, 30, 1, 1, 1, 1, 20, 1, 0);
    vt[18] = mk(0, 0,  0, 1, 1, 1, 30, 1, 0);
    vt[19] = mk(0, 0,  0, 1, 1, 0, 30, 1, 0);

    // Reset state, with prod_last high so the ready rule is exercised.
    repeat (2) @(posedge clk);
    #1;
    check("reset.prod_ready", m_if.prod_ready, 1'b1);
    m_check_outputs("reset", 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      m_if.prod_valid = vt[i].pv;
      m_if.prod_data  = vt[i].pd;
      m_if.prod_last  = vt[i].pl;
      m_if.sum_ready  = vt[i].sr;
      #1;
      check($sformatf("vec%0d.prod_ready", i), m_if.prod_ready, vt[i].rdy);
      m_check_outputs($sformatf("vec%0d", i), vt[i].sv, vt[i].sd, vt[i].sc, vt[i].so);
    end

    // Mid-frame reset with a result pending discards both.
    @(posedge clk); #1;
    m_if.prod_valid = 1'b1; m_if.prod_data = 50; m_if.prod_last = 1'b1; m_if.sum_ready = 1'b0;
    @(posedge clk); #1;
    m_if.prod_data = 100; m_if.prod_last = 1'b0;
    #1;
    m_check_outputs("abort.pending", 1'b1, 50, 1, 1'b0);
    @(posedge clk); #1;
    m_if.prod_data = 200;
    @(posedge clk); #1;
    m_if.prod_valid = 1'b0; m_if.prod_last = 1'b1;
    rst_n = 1'b0;
    #1;
    check("abort.in_reset.prod_ready", m_if.prod_ready, 1'b1);
    m_check_outputs("abort.in_reset", 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    m_if.prod_valid = 1'b1; m_if.prod_data = 7; m_if.prod_last = 1'b1; m_if.sum_ready = 1'b1;
    @(posedge clk); #1;
    m_if.prod_valid = 1'b0; m_if.prod_last = 1'b0;
    #1;
    m_check_outputs("abort.next", 1'b1, 7, 1, 1'b0);
    @(posedge clk); #2;
    m_check_outputs("abort.drained", 1'b0, 7, 1, 1'b0);

    // Narrow instance: overflow, recovery, count saturation.
    s_beat(16'hFFF0, 1'b0);
    s_beat(16'h0020, 1'b0);
    s_beat(16'h0005, 1'b1);
    s_result("narrow.ovf", 16'hFFFF, 3, 1'b1);
    s_beat(16'h0001, 1'b1);
    s_result("narrow.after_ovf", 1, 1, 1'b0);
    for (int k = 0; k < 5; k++) s_beat(16'h0001, (k == 4));
    s_result("narrow.cnt_sat", 5, 3, 1'b0);

    // Randomized run against the frame model.
    do_reset();
    mq.delete();
    msum = 0;
    mn   = 0;
    last_out = '{data: 0, cnt: 0, ovf: 1'b0};
    random_phase(2000, 6, 0);
    random_phase(3000, 600, 60000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
